// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared hold-level encodings, controller state encoding and watchdog default
// for the pipeline hold controller and its counters.
package pipe_hold_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD_NONE = 3'b000,
        HOLD_PC   = 3'b001,
        HOLD_IF   = 3'b010,
        HOLD_ID   = 3'b011
    } hold_e;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_JFLUSH = 2'd1,
        S_MCWAIT = 2'd2
    } state_e;

    localparam int MC_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/pipe_hold_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/redirect controller: arbitrates jump, divider wait, interrupt
// hold and load-use stalls into one hold level, with a divider watchdog.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = MC_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        mc_busy_i,
    input  logic        irq_hold_i,
    input  logic        ld_use_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        mc_timeout_o,
    output logic [31:0] stall_cycles_o
);

    localparam int WD_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

    state_e          state_reg;
    state_e          state_next;
    hold_e           hold_next;
    hold_e           low_prio_hold;
    logic            wd_inc;
    logic            wd_clr;
    logic [WD_W-1:0] wd_count;
    logic            timeout_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Interrupt hold and load-use only matter once no jump or divider wait applies.
    always_comb begin
        low_prio_hold = HOLD_NONE;
        if (irq_hold_i) begin
            low_prio_hold = HOLD_ID;
        end else if (ld_use_i) begin
            low_prio_hold = HOLD_PC;
        end
    end

    always_comb begin
        state_next  = state_reg;
        hold_next   = HOLD_NONE;
        jump_flag_o = 1'b0;
        jump_addr_o = 32'd0;
        wd_inc      = 1'b0;
        wd_clr      = 1'b0;
        if (!rst) begin
            state_next = S_RUN;
            wd_clr     = 1'b1;
        end else if (jump_flag_i) begin
            jump_flag_o = 1'b1;
            jump_addr_o = jump_addr_i;
            hold_next   = HOLD_ID;
            state_next  = S_JFLUSH;
            wd_clr      = 1'b1;
        end else begin
            unique case (state_reg)
                S_JFLUSH: begin
                    // Busy seen here is picked up from RUN on the next cycle.
                    hold_next  = HOLD_IF;
                    state_next = S_RUN;
                end
                S_MCWAIT: begin
                    if (mc_busy_i) begin
                        hold_next = HOLD_ID;
                        wd_inc    = 1'b1;
                    end else begin
                        hold_next  = low_prio_hold;
                        state_next = S_RUN;
                        wd_clr     = 1'b1;
                    end
                end
                default: begin
                    if (mc_busy_i) begin
                        hold_next  = HOLD_ID;
                        state_next = S_MCWAIT;
                    end else begin
                        hold_next = low_prio_hold;
                    end
                end
            endcase
        end
    end

    sat_cnt #(
        .WIDTH(WD_W)
    ) u_watchdog (
        .clk  (clk),
        .rst  (rst),
        .inc  (wd_inc),
        .clr  (wd_clr),
        .count(wd_count)
    );

    sat_cnt #(
        .WIDTH(32)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (hold_next != HOLD_NONE),
        .clr  (1'b0),
        .count(stall_cycles_o)
    );

    // Sticky: fires on the wait cycle that brings the count up to MC_TIMEOUT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_reg <= 1'b0;
        end else if (wd_inc && (wd_count >= WD_LAST)) begin
            timeout_reg <= 1'b1;
        end
    end

    assign hold_flag_o  = hold_next;
    assign mc_timeout_o = timeout_reg;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl: directed scenarios then random
// traffic, compared each cycle against a behavioural reference model.
module tb_pipe_hold_ctrl;

    localparam int MC_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        mc_busy_i = 1'b0;
    logic        irq_hold_i = 1'b0;
    logic        ld_use_i = 1'b0;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        mc_timeout_o;
    logic [31:0] stall_cycles_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: a pending one-cycle flush after a jump, an ongoing
    // divider wait, how many busy cycles that wait has lasted, sticky error.
    bit     flush_pending = 1'b0;
    bit     waiting = 1'b0;
    int     wait_cycles = 0;
    bit     m_timeout = 1'b0;
    longint m_stalls = 0;

    pipe_hold_ctrl #(
        .MC_TIMEOUT(MC_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .mc_busy_i     (mc_busy_i),
        .irq_hold_i    (irq_hold_i),
        .ld_use_i      (ld_use_i),
        .hold_flag_o   (hold_flag_o),
        .jump_flag_o   (jump_flag_o),
        .jump_addr_o   (jump_addr_o),
        .mc_timeout_o  (mc_timeout_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic cycle(input logic r, input logic j, input logic [31:0] a,
                         input logic b, input logic i, input logic l);
        logic [2:0]  e_hold;
        logic        e_jf;
        logic [31:0] e_addr;
        rst = r; jump_flag_i = j; jump_addr_i = a;
        mc_busy_i = b; irq_hold_i = i; ld_use_i = l;
        #1;
        e_hold = 3'd0; e_jf = 1'b0; e_addr = 32'd0;
        if (r) begin
            if (j) begin e_hold = 3'd3; e_jf = 1'b1; e_addr = a; end
            else if (flush_pending) e_hold = 3'd2;
            else if (b || i) e_hold = 3'd3;
            else if (l) e_hold = 3'd1;
        end
        chk("hold_flag", {29'd0, hold_flag_o}, {29'd0, e_hold});
        chk("jump_flag", {31'd0, jump_flag_o}, {31'd0, e_jf});
        chk("jump_addr", jump_addr_o, e_addr);
        chk("mc_timeout", {31'd0, mc_timeout_o}, {31'd0, m_timeout});
        chk("stall_cycles", stall_cycles_o, m_stalls[31:0]);
        @(posedge clk);
        if (!r) begin
            flush_pending = 1'b0; waiting = 1'b0; wait_cycles = 0;
            m_timeout = 1'b0; m_stalls = 0;
        end else begin
            if (e_hold != 3'd0 && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            if (j) begin
                flush_pending = 1'b1; waiting = 1'b0; wait_cycles = 0;
            end else if (flush_pending) begin
                flush_pending = 1'b0;
            end else if (b) begin
                if (waiting) begin
                    wait_cycles++;
                    if (wait_cycles >= MC_TIMEOUT) m_timeout = 1'b1;
                end
                waiting = 1'b1;
            end else begin
                waiting = 1'b0; wait_cycles = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic busy_lvl;
        @(negedge clk);
        repeat (2) cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Jump: 011 with target, then 010, then 000.
        cycle(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Five busy cycles from a clean reset.
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("busy5_stalls", stall_cycles_o, 32'd5);
        chk("busy5_timeout", {31'd0, mc_timeout_o}, 32'd0);

        // Load-use one cycle, interrupt hold three cycles.
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Jump beats busy and load-use; busy honoured after the flush.
        cycle(1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Watchdog: 70 busy cycles, sticky after busy drops, cleared by reset.
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (70) cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("timeout_sticky", {31'd0, mc_timeout_o}, 32'd1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("timeout_cleared", {31'd0, mc_timeout_o}, 32'd0);

        // Reset in the middle of a divider wait, busy held through release.
        repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("reset_stalls", stall_cycles_o, 32'd0);
        repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Random traffic with a level-like busy signal.
        busy_lvl = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) busy_lvl = ~busy_lvl;
            cycle($urandom_range(0, 99) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom,
                  busy_lvl,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_hold_ctrl.md
PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; no other clock or reset.
REQ-002 Parameter MC_TIMEOUT, default 64, cycles in MCWAIT before mc_timeout_o sets.
REQ-003 Port clk  input  1  pipeline clock, all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous active-low reset.
REQ-005 Port jump_flag_i  input  1  EX requests redirect this cycle.
REQ-006 Port jump_addr_i  input  32  redirect target.
REQ-007 Port mc_busy_i  input  1  multi-cycle unit (divider) busy, level.
REQ-008 Port irq_hold_i  input  1  interrupt controller requests pipeline hold, level.
REQ-009 Port ld_use_i  input  1  ID detects load-use hazard this cycle.
REQ-010 Port hold_flag_o  output  3  hold level driven to PC and pipe registers.
REQ-011 Port jump_flag_o  output  1  redirect strobe to PC register.
REQ-012 Port jump_addr_o  output  32  redirect target to PC register.
REQ-013 Port mc_timeout_o  output  1  sticky multi-cycle watchdog error.
REQ-014 Port stall_cycles_o  output  32  saturating count of held cycles.

Function
REQ-015 hold_flag_o encoding SHALL be: 000 NONE; 001 HOLD_PC (PC frozen); 010 HOLD_IF (PC frozen, IF/ID loads NOP); 011 HOLD_ID (PC frozen, IF/ID and ID/EX load default/NOP); other codes never driven.
REQ-016 hold_flag_o, jump_flag_o, jump_addr_o SHALL be combinational from registered state and current inputs (zero latency); mc_timeout_o and stall_cycles_o SHALL be registered.
REQ-017 FSM states SHALL be RUN, JFLUSH, MCWAIT.
REQ-018 Request priority in any state SHALL be jump_flag_i > mc_busy_i > irq_hold_i > ld_use_i.
REQ-019 jump_flag_i=1 in any state: jump_flag_o=1, jump_addr_o=jump_addr_i, hold_flag_o=HOLD_ID, next state JFLUSH, watchdog counter cleared.
REQ-020 jump_flag_o=0 SHALL force jump_addr_o=0.
REQ-021 JFLUSH without new jump: hold_flag_o=HOLD_IF for exactly one cycle, next state RUN; mc_busy_i that cycle is taken next cycle from RUN.
REQ-022 RUN, mc_busy_i=1: hold_flag_o=HOLD_ID, next MCWAIT.
REQ-023 MCWAIT: hold_flag_o=HOLD_ID while mc_busy_i=1; first cycle with mc_busy_i=0 drives NONE (or lower-priority request level) and returns to RUN.
REQ-024 Watchdog counter SHALL increment each cycle in MCWAIT with mc_busy_i=1, clear on leaving MCWAIT; reaching MC_TIMEOUT sets mc_timeout_o, held until reset; FSM behaviour unaffected.
REQ-025 RUN, only irq_hold_i=1: hold_flag_o=HOLD_ID every cycle asserted, state stays RUN.
REQ-026 RUN, only ld_use_i=1: hold_flag_o=HOLD_PC that cycle, state stays RUN.
REQ-027 stall_cycles_o SHALL increment by 1 each cycle hold_flag_o!=NONE, saturate at 32'hFFFF_FFFF.

Reset
REQ-028 While rst=0 at a clock edge: state RUN, watchdog 0, mc_timeout_o=0, stall_cycles_o=0.
REQ-029 During reset, hold_flag_o SHALL be NONE and jump_flag_o=0, jump_addr_o=0 regardless of inputs.
REQ-030 Reset asserted mid-MCWAIT or mid-JFLUSH SHALL abandon the sequence; first post-reset cycle is RUN.

Structure
REQ-031 Hold encodings, FSM state encoding and MC_TIMEOUT default SHALL live in the shared instruction/define include.
REQ-032 Saturating counter SHALL be one sub-module sat_cnt (width parameter, inc, clr), used for stall_cycles_o and watchdog.

Verification
REQ-033 jump_flag_i=1, addr 0x0000_0100 one cycle -> cycle0 jump_flag_o=1, addr 0x100, hold 011; cycle1 hold 010; cycle2 hold 000.
REQ-034 mc_busy_i high 5 cycles -> hold 011 for 5 cycles, 000 on 6th, stall_cycles_o=5, mc_timeout_o=0.
REQ-035 mc_busy_i high 70 cycles, MC_TIMEOUT=64 -> mc_timeout_o=1 from cycle 65, stays 1 after busy drops until rst=0.
REQ-036 jump_flag_i and mc_busy_i and ld_use_i same cycle -> jump wins (hold 011, jump_flag_o=1), JFLUSH next, MCWAIT entered cycle after.
REQ-037 ld_use_i one cycle in RUN -> hold 001 that cycle only; irq_hold_i 3 cycles -> hold 011 three cycles.
REQ-038 rst=0 during MCWAIT with mc_busy_i=1 -> outputs 000/0, stall_cycles_o=0; after release with busy still 1 -> MCWAIT re-entered from RUN.
